// File: rtl/shift_rows_engine.sv
// shift_rows_engine: registered AES/Rijndael ShiftRows (forward or inverse)
// with a valid/ready handshake on both sides and a delivered-block counter.
//
// Build option: define SHIFT_ROWS_SKID_EN to add a skid register behind the
// output register. inReady then comes from a flop and no longer depends on
// outReady combinationally. Without it, the engine holds a single state.
//
// State layout is column-major: byte s[r][c] lives at bits [W-1-8*(r+4c) -: 8].
module shift_rows_engine #(
    parameter int  NB = 4,
    localparam int W  = 32 * NB
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] prevState,
    input  logic         invMode,
    input  logic         inValid,
    output logic         inReady,
    output logic [W-1:0] nextState,
    output logic         outValid,
    input  logic         outReady,
    output logic [15:0]  blkCount
);

    // Only the Rijndael block sizes 128/192/256 have defined row offsets.
    generate
        if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
            $fatal(1, "shift_rows_engine: NB must be 4, 6 or 8");
        end
    endgenerate

    // Row offsets: 0,1,2,3 for 128/192-bit blocks; 256-bit blocks use 0,1,3,4.
    function automatic int row_shift(input int r);
        int sh;
        case (r)
            0:       sh = 0;
            1:       sh = 1;
            2:       sh = (NB == 8) ? 3 : 2;
            default: sh = (NB == 8) ? 4 : 3;
        endcase
        return sh;
    endfunction

    // Pure byte permutation; every index is a loop constant after unrolling,
    // so this is wiring plus a 2:1 mux per byte for the direction select.
    function automatic logic [W-1:0] shift_rows(input logic [W-1:0] s, input logic inv);
        logic [W-1:0] res;
        int           src_fwd;
        int           src_inv;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < NB; c++) begin
                src_fwd = (c + row_shift(r)) % NB;
                src_inv = (c + NB - row_shift(r)) % NB;
                if (inv) begin
                    res[W-1-8*(r+4*c) -: 8] = s[W-1-8*(r+4*src_inv) -: 8];
                end else begin
                    res[W-1-8*(r+4*c) -: 8] = s[W-1-8*(r+4*src_fwd) -: 8];
                end
            end
        end
        return res;
    endfunction

    logic [W-1:0] shifted;
    logic         in_xfer;
    logic         out_xfer;

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q,  out_data_d;
    logic [15:0]  blk_cnt_q,   blk_cnt_d;

`ifdef SHIFT_ROWS_SKID_EN
    logic         skid_full_q, skid_full_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         in_ready_q,  in_ready_d;

    // Registered ready: low whenever the skid slot is (or is about to be) occupied.
    assign inReady = in_ready_q;
`else
    logic         rdy_q, rdy_d;

    // rdy_q keeps inReady low during reset; otherwise accept whenever the
    // single output slot is empty or being drained this edge.
    assign inReady = rdy_q && (!out_valid_q || outReady);
`endif

    assign in_xfer   = inValid && inReady;
    assign out_xfer  = out_valid_q && outReady;
    assign outValid  = out_valid_q;
    assign nextState = out_data_q;
    assign blkCount  = blk_cnt_q;

    // Compute the permuted input state for whichever slot captures it.
    always_comb begin
        shifted = shift_rows(prevState, invMode);
    end

    // Next-state for the output slot, the optional skid slot and the counter.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        blk_cnt_d   = blk_cnt_q + {15'd0, out_xfer};
`ifdef SHIFT_ROWS_SKID_EN
        skid_full_d = skid_full_q;
        skid_data_d = skid_data_q;
        if (!out_valid_q || outReady) begin
            // Output slot is free after this edge: refill from skid first to
            // keep acceptance order, otherwise from the input.
            if (skid_full_q) begin
                out_valid_d = 1'b1;
                out_data_d  = skid_data_q;
                skid_full_d = 1'b0;
            end else if (in_xfer) begin
                out_valid_d = 1'b1;
                out_data_d  = shifted;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            // Output is stalled: park the newly accepted state in the skid slot.
            skid_full_d = 1'b1;
            skid_data_d = shifted;
        end
        in_ready_d = !skid_full_d;
`else
        rdy_d = 1'b1;
        if (in_xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = shifted;
        end else if (out_xfer) begin
            out_valid_d = 1'b0;
        end
`endif
    end

    // State registers; reset clears data too so nextState reads zero in reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            blk_cnt_q   <= '0;
`ifdef SHIFT_ROWS_SKID_EN
            skid_full_q <= 1'b0;
            skid_data_q <= '0;
            in_ready_q  <= 1'b0;
`else
            rdy_q       <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            blk_cnt_q   <= blk_cnt_d;
`ifdef SHIFT_ROWS_SKID_EN
            skid_full_q <= skid_full_d;
            skid_data_q <= skid_data_d;
            in_ready_q  <= in_ready_d;
`else
            rdy_q       <= rdy_d;
`endif
        end
    end

endmodule

// File: tb/tb_shift_rows_engine.sv
// Bench for shift_rows_engine: NB=4 instance (main protocol and data checks)
// plus an NB=8 instance for the 256-bit offset table.
module tb_shift_rows_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic [127:0] prev4, next4;
    logic         inv4, iv4, ir4, ov4, or4;
    logic [15:0]  cnt4;

    logic [255:0] p8, n8;
    logic         inv8, iv8, ir8, ov8, or8;
    logic [15:0]  cnt8;

    shift_rows_engine #(.NB(4)) dut4 (
        .clk(clk), .reset(reset), .prevState(prev4), .invMode(inv4),
        .inValid(iv4), .inReady(ir4), .nextState(next4), .outValid(ov4),
        .outReady(or4), .blkCount(cnt4)
    );

    shift_rows_engine #(.NB(8)) dut8 (
        .clk(clk), .reset(reset), .prevState(p8), .invMode(inv8),
        .inValid(iv8), .inReady(ir8), .nextState(n8), .outValid(ov8),
        .outReady(or8), .blkCount(cnt8)
    );

    int           total = 0;
    int           bad   = 0;
    logic [255:0] sb[$];
    logic [15:0]  exp_cnt;
    logic         held;
    logic [127:0] held_val;
    int           accepts;

`ifdef SHIFT_ROWS_SKID_EN
    localparam int STALL_ACCEPTS = 2;
`else
    localparam int STALL_ACCEPTS = 1;
`endif

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: unpack into a row/column byte grid, rotate rows by the offset
    // table. Forward gathers from column c+sh; inverse scatters column c to c+sh.
    function automatic logic [255:0] model(input logic [255:0] v, input int nb, input bit inv);
        logic [7:0]   b [4][8];
        logic [255:0] o;
        int           sh;
        int           d;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < nb; c++)
                b[r][c] = v[32*nb-1-8*(r+4*c) -: 8];
        for (int r = 0; r < 4; r++) begin
            sh = (nb == 8 && r >= 2) ? r + 1 : r;
            for (int c = 0; c < nb; c++) begin
                d = (c + sh) % nb;
                if (!inv) o[32*nb-1-8*(r+4*c) -: 8] = b[r][d];
                else      o[32*nb-1-8*(r+4*d) -: 8] = b[r][c];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One clock of the NB=4 instance: observe transfers before the edge,
    // score outputs against the queue, enqueue accepted inputs.
    task automatic tick();
        #2;
        if (held) begin
            check("hold_valid", 256'(ov4), 256'd1);
            check("hold_data", 256'(next4), 256'(held_val));
        end
        held     = ov4 && !or4;
        held_val = next4;
        if (ov4 && or4) begin
            if (sb.size() == 0) check("unexpected_out", 256'(ov4), 256'd0);
            else check("order_data", 256'(next4), sb.pop_front());
            exp_cnt++;
        end
        if (iv4 && ir4) begin
            sb.push_back(model(256'(prev4), 4, inv4));
            accepts++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1500000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic [255:0] orig8;
        logic [15:0]  base;
        int           n;

        reset = 1'b1; prev4 = '0; inv4 = 1'b0; iv4 = 1'b0; or4 = 1'b0;
        p8 = '0; inv8 = 1'b0; iv8 = 1'b0; or8 = 1'b1;
        held = 1'b0; exp_cnt = '0; accepts = 0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_outValid", 256'(ov4), 256'd0);
        check("rst_nextState", 256'(next4), 256'd0);
        check("rst_blkCount", 256'(cnt4), 256'd0);
        check("rst_inReady", 256'(ir4), 256'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_release", 256'(ir4), 256'd1);

        // forward NB=4 known vector, 1-cycle latency
        prev4 = 128'h000102030405060708090a0b0c0d0e0f; inv4 = 1'b0; iv4 = 1'b1; or4 = 1'b1;
        tick();
        iv4 = 1'b0;
        check("fwd_valid", 256'(ov4), 256'd1);
        check("fwd_data", 256'(next4), 256'(128'h00050a0f04090e03080d02070c01060b));
        check("fwd_cnt_before", 256'(cnt4), 256'd0);
        tick();
        check("fwd_cnt_after", 256'(cnt4), 256'd1);
        check("fwd_drained", 256'(ov4), 256'd0);

        // inverse NB=4 known vector
        prev4 = 128'h00050a0f04090e03080d02070c01060b; inv4 = 1'b1; iv4 = 1'b1;
        tick();
        iv4 = 1'b0;
        check("inv_data", 256'(next4), 256'(128'h000102030405060708090a0b0c0d0e0f));
        tick();

        // NB=8 forward then inverse round trip
        for (int k = 0; k < 32; k++) p8[255-8*k -: 8] = 8'(k);
        orig8 = p8;
        inv8 = 1'b0; iv8 = 1'b1;
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        check("nb8_valid", 256'(ov8), 256'd1);
        check("nb8_r3c0", 256'(n8[255-8*3 -: 8]), 256'h13);
        check("nb8_r2c0", 256'(n8[255-8*2 -: 8]), 256'h0e);
        check("nb8_fwd", n8, model(orig8, 8, 1'b0));
        p8 = n8; inv8 = 1'b1; iv8 = 1'b1;
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        check("nb8_roundtrip", n8, orig8);

        // back-pressure: outReady low for 5 cycles with inValid high
        or4 = 1'b0; accepts = 0; base = exp_cnt;
        for (int i = 0; i < 5; i++) begin
            prev4 = rnd128(); inv4 = 1'($urandom_range(0, 1)); iv4 = 1'b1;
            tick();
        end
        check("stall_accepts", 256'(accepts), 256'(STALL_ACCEPTS));
        check("stall_inReady", 256'(ir4), 256'd0);
        iv4 = 1'b0; or4 = 1'b1;
        repeat (3) tick();
        check("stall_drain_cnt", 256'(cnt4), 256'(base + 16'(STALL_ACCEPTS)));
        check("stall_queue_empty", 256'(sb.size()), 256'd0);

        // randomized traffic with random back-pressure
        for (int i = 0; i < 400; i++) begin
            iv4 = 1'($urandom_range(0, 1));
            or4 = ($urandom_range(0, 3) != 0);
            prev4 = rnd128(); inv4 = 1'($urandom_range(0, 1));
            tick();
        end
        iv4 = 1'b0; or4 = 1'b1;
        repeat (3) tick();
        check("rand_queue_empty", 256'(sb.size()), 256'd0);
        check("rand_cnt", 256'(cnt4), 256'(exp_cnt));

        // counter wrap at 0xFFFF
        iv4 = 1'b1; or4 = 1'b1; n = 0;
        while (cnt4 !== 16'hFFFF && n < 70000) begin
            prev4 = rnd128(); inv4 = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        iv4 = 1'b0;
        check("cnt_reach_ffff", 256'(cnt4), 256'h0ffff);
        check("cnt_model_ffff", 256'(cnt4), 256'(exp_cnt));
        check("valid_before_wrap", 256'(ov4), 256'd1);
        tick();
        check("cnt_wrap", 256'(cnt4), 256'd0);
        tick();

        // asynchronous reset while holding a valid output
        prev4 = rnd128(); iv4 = 1'b1; or4 = 1'b0;
        tick();
        iv4 = 1'b0;
        check("pre_reset_valid", 256'(ov4), 256'd1);
        #2 reset = 1'b1;
        #1;
        held = 1'b0;
        check("async_rst_outValid", 256'(ov4), 256'd0);
        check("async_rst_nextState", 256'(next4), 256'd0);
        check("async_rst_blkCount", 256'(cnt4), 256'd0);
        check("async_rst_inReady", 256'(ir4), 256'd0);
        sb.delete(); exp_cnt = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_inReady", 256'(ir4), 256'd1);
        check("post_rst_outValid", 256'(ov4), 256'd0);
        check("post_rst_blkCount", 256'(cnt4), 256'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
